// File: rtl/dcpu_operand_fetch.sv
// dcpu_operand_fetch
//
// Resolves one DCPU operand field (a or b) to its value and effective address.
// The block sits between the decode stage and the RAM port. It reads the
// nextword and the indirect operand through a req/ack read port, and applies the
// PUSH/POP stack-pointer update. When WAIT_TICKS is nonzero, it inserts idle
// ticks after each memory access so that cycle counts match the original core.
//
// Ports
//   CORE_CLK  clock; every flop updates on the falling edge
//   RESET     asynchronous, active-high reset
//   start     begin a resolve; sampled only while idle
//   is_b      1: field is operand b (destination), 0: operand a (source)
//   field     6-bit operand encoding
//   regs      A,B,C,X,Y,Z,I,J packed, with A at [W-1:0]
//   sp_in, pc_in, ex_in   SP, PC (already past the instruction word), EX
//   mem_req, mem_addr     read request; the address is stable while mem_req=1
//   mem_ack, mem_rdata    read complete; rdata is valid in the ack cycle
//   busy      the block is not idle
//   done      one-cycle pulse; the result outputs are valid from this cycle on
//   value, ea, ea_valid   operand value, effective address, memory-target flag
//   pc_next, sp_next      PC after any nextword, SP after PUSH/POP
//   nw_used   a nextword was consumed
//   illegal   a short literal was given as operand b
module dcpu_operand_fetch #(
   parameter int W          = 16,
   parameter int WAIT_TICKS = 0
) (
   input  logic           CORE_CLK,
   input  logic           RESET,
   input  logic           start,
   input  logic           is_b,
   input  logic [5:0]     field,
   input  logic [8*W-1:0] regs,
   input  logic [W-1:0]   sp_in,
   input  logic [W-1:0]   pc_in,
   input  logic [W-1:0]   ex_in,
   output logic           mem_req,
   output logic [W-1:0]   mem_addr,
   input  logic           mem_ack,
   input  logic [W-1:0]   mem_rdata,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   value,
   output logic [W-1:0]   ea,
   output logic           ea_valid,
   output logic [W-1:0]   pc_next,
   output logic [W-1:0]   sp_next,
   output logic           nw_used,
   output logic           illegal
);

   typedef enum logic [2:0] {
      IDLE, NW_REQ, NW_WAIT, IND_REQ, IND_WAIT, DONE
   } state_t;

   localparam int CNT_W = (WAIT_TICKS > 0) ? $clog2(WAIT_TICKS + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'((WAIT_TICKS > 0) ? WAIT_TICKS - 1 : 0);

   state_t           state_q, state_d;
   logic [5:0]       field_q, field_d;
   logic [W-1:0]     r_q, r_d;      // register selected by field[2:0]
   logic [W-1:0]     sp_q, sp_d;
   logic [W-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     value_q, value_d;
   logic [W-1:0]     ea_q, ea_d;
   logic             ea_valid_q, ea_valid_d;
   logic [W-1:0]     pc_next_q, pc_next_d;
   logic [W-1:0]     sp_next_q, sp_next_d;
   logic             nw_used_q, nw_used_d;
   logic             illegal_q, illegal_d;

   logic [W-1:0]     r_in;
   state_t           after_nw;      // where to go once the nextword is in hand

   assign r_in     = regs[int'(field[2:0]) * W +: W];
   assign after_nw = (field_q == 6'h1F) ? DONE : IND_REQ;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      field_d    = field_q;
      r_d        = r_q;
      sp_d       = sp_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      value_d    = value_q;
      ea_d       = ea_q;
      ea_valid_d = ea_valid_q;
      pc_next_d  = pc_next_q;
      sp_next_d  = sp_next_q;
      nw_used_d  = nw_used_q;
      illegal_d  = illegal_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               field_d    = field;
               r_d        = r_in;
               sp_d       = sp_in;
               pc_d       = pc_in;
               cnt_d      = '0;
               value_d    = '0;
               ea_d       = '0;
               ea_valid_d = 1'b0;
               pc_next_d  = pc_in;
               sp_next_d  = sp_in;
               nw_used_d  = 1'b0;
               illegal_d  = 1'b0;
               if (field[5]) begin
                  // Short literal: field-0x21 taken modulo 2^W is the sign extension.
                  if (is_b) illegal_d = 1'b1;
                  else      value_d   = {{(W-6){1'b0}}, field} - W'(33);
                  state_d = DONE;
               end else begin
                  unique case (field[4:3])
                     2'b00: begin value_d = r_in; state_d = DONE; end
                     2'b01: begin ea_d = r_in; ea_valid_d = 1'b1; state_d = IND_REQ; end
                     2'b10: begin ea_valid_d = 1'b1; state_d = NW_REQ; end
                     default: begin
                        unique case (field[2:0])
                           3'd0: begin
                              ea_valid_d = 1'b1;
                              state_d    = IND_REQ;
                              if (is_b) begin
                                 ea_d      = sp_in - 1'b1;
                                 sp_next_d = sp_in - 1'b1;
                              end else begin
                                 ea_d      = sp_in;
                                 sp_next_d = sp_in + 1'b1;
                              end
                           end
                           3'd1: begin ea_d = sp_in; ea_valid_d = 1'b1; state_d = IND_REQ; end
                           3'd2: begin ea_valid_d = 1'b1; state_d = NW_REQ; end
                           3'd3: begin value_d = sp_in; state_d = DONE; end
                           3'd4: begin value_d = pc_in; state_d = DONE; end
                           3'd5: begin value_d = ex_in; state_d = DONE; end
                           3'd6: begin ea_valid_d = 1'b1; state_d = NW_REQ; end
                           default: state_d = NW_REQ;
                        endcase
                     end
                  endcase
               end
            end
         end

         NW_REQ: begin
            if (mem_ack) begin
               nw_used_d = 1'b1;
               pc_next_d = pc_q + 1'b1;
               if (field_q[4:3] == 2'b10)  ea_d    = r_q + mem_rdata;
               else if (field_q == 6'h1A)  ea_d    = sp_q + mem_rdata;
               else if (field_q == 6'h1E)  ea_d    = mem_rdata;
               else                        value_d = mem_rdata;
               state_d = (WAIT_TICKS > 0) ? NW_WAIT : after_nw;
            end
         end

         NW_WAIT: begin
            if (cnt_q == LAST_TICK) begin
               cnt_d   = '0;
               state_d = after_nw;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         IND_REQ: begin
            if (mem_ack) begin
               value_d = mem_rdata;
               state_d = (WAIT_TICKS > 0) ? IND_WAIT : DONE;
            end
         end

         IND_WAIT: begin
            if (cnt_q == LAST_TICK) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;   // DONE lasts exactly one cycle
      endcase
   end

   always_ff @(negedge CORE_CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         field_q    <= '0;
         r_q        <= '0;
         sp_q       <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
         value_q    <= '0;
         ea_q       <= '0;
         ea_valid_q <= 1'b0;
         pc_next_q  <= '0;
         sp_next_q  <= '0;
         nw_used_q  <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments, so every flop samples the pre-edge values.
         state_q    <= state_d;
         field_q    <= field_d;
         r_q        <= r_d;
         sp_q       <= sp_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         value_q    <= value_d;
         ea_q       <= ea_d;
         ea_valid_q <= ea_valid_d;
         pc_next_q  <= pc_next_d;
         sp_next_q  <= sp_next_d;
         nw_used_q  <= nw_used_d;
         illegal_q  <= illegal_d;
      end
   end

   // mem_req and mem_addr decode straight from the state, so RESET drops the request asynchronously.
   assign mem_req  = (state_q == NW_REQ) || (state_q == IND_REQ);
   assign mem_addr = (state_q == NW_REQ)  ? pc_q :
                     (state_q == IND_REQ) ? ea_q : '0;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign value    = value_q;
   assign ea       = ea_q;
   assign ea_valid = ea_valid_q;
   assign pc_next  = pc_next_q;
   assign sp_next  = sp_next_q;
   assign nw_used  = nw_used_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_dcpu_operand_fetch.sv
// Testbench for dcpu_operand_fetch. dut0 runs with WAIT_TICKS=0 and dut1 with
// WAIT_TICKS=3. The driver pushes the expected result into a queue for each
// request. A monitor pops that entry on every done pulse and compares it.
module tb_dcpu_operand_fetch;

   typedef struct {
      int          id;
      string       name;
      logic [15:0] value, ea, pc_next, sp_next;
      logic        ea_valid, nw_used, illegal;
      int          nacc;
      logic [15:0] a0, a1;
      int          lat;
      int          idle;
      int          reqc;
   } exp_t;

   logic             clk, RESET;
   logic [1:0]       start_v;
   logic             is_b_i;
   logic [5:0]       field_i;
   logic [127:0]     regs_i;
   logic [15:0]      sp_i, pc_i, ex_i;
   logic [1:0]       mem_req_v, mem_ack_v, busy_v, done_v, ea_valid_v, nw_used_v, illegal_v;
   logic [1:0][15:0] mem_addr_v, rdata_v, value_v, ea_v, pc_next_v, sp_next_v;

   logic [15:0] mem [logic [15:0]];
   logic [15:0] acc_log [$];
   exp_t        sb [$];
   int          ack_dly = 2;
   int          n_tests = 0;
   int          n_fail  = 0;

   dcpu_operand_fetch #(.W(16), .WAIT_TICKS(0)) u_dut0 (
      .CORE_CLK(clk), .RESET(RESET), .start(start_v[0]), .is_b(is_b_i), .field(field_i),
      .regs(regs_i), .sp_in(sp_i), .pc_in(pc_i), .ex_in(ex_i),
      .mem_req(mem_req_v[0]), .mem_addr(mem_addr_v[0]), .mem_ack(mem_ack_v[0]), .mem_rdata(rdata_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .value(value_v[0]), .ea(ea_v[0]), .ea_valid(ea_valid_v[0]),
      .pc_next(pc_next_v[0]), .sp_next(sp_next_v[0]), .nw_used(nw_used_v[0]), .illegal(illegal_v[0]));

   dcpu_operand_fetch #(.W(16), .WAIT_TICKS(3)) u_dut1 (
      .CORE_CLK(clk), .RESET(RESET), .start(start_v[1]), .is_b(is_b_i), .field(field_i),
      .regs(regs_i), .sp_in(sp_i), .pc_in(pc_i), .ex_in(ex_i),
      .mem_req(mem_req_v[1]), .mem_addr(mem_addr_v[1]), .mem_ack(mem_ack_v[1]), .mem_rdata(rdata_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .value(value_v[1]), .ea(ea_v[1]), .ea_valid(ea_valid_v[1]),
      .pc_next(pc_next_v[1]), .sp_next(sp_next_v[1]), .nw_used(nw_used_v[1]), .illegal(illegal_v[1]));

   // The DUT is active on the falling edge. The bench drives and samples around the rising edge.
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : 16'hDEAD;
   endfunction

   function automatic exp_t mk(input int id, input string name, input logic [15:0] value, ea,
                               input logic eav, input logic [15:0] pcn, spn, input logic nw, ill,
                               input int nacc, input logic [15:0] a0, a1, input int lat, idle);
      exp_t e;
      e.id = id; e.name = name; e.value = value; e.ea = ea; e.ea_valid = eav;
      e.pc_next = pcn; e.sp_next = spn; e.nw_used = nw; e.illegal = ill;
      e.nacc = nacc; e.a0 = a0; e.a1 = a1; e.lat = lat; e.idle = idle; e.reqc = 0;
      return e;
   endfunction

   // Memory responder. It raises ack ack_dly cycles into each request and logs every acked address.
   initial begin
      int  cnt [2];
      logic prev;
      cnt[0] = 0; cnt[1] = 0;
      mem_ack_v = '0;
      rdata_v   = '0;
      forever begin
         @(posedge clk);
         for (int id = 0; id < 2; id++) begin
            if (RESET) begin
               mem_ack_v[id] = 1'b0;
               cnt[id]       = 0;
            end else begin
               prev          = mem_ack_v[id];
               mem_ack_v[id] = 1'b0;
               if (prev) cnt[id] = 0;
               if (mem_req_v[id]) begin
                  cnt[id]++;
                  if (cnt[id] >= ack_dly) begin
                     mem_ack_v[id] = 1'b1;
                     rdata_v[id]   = rd(mem_addr_v[id]);
                     acc_log.push_back(mem_addr_v[id]);
                  end
               end
            end
         end
      end
   end

   // Monitor: measures latency, request cycles and idle ticks, then checks each done against the queue.
   initial begin
      int   cyc, reqc, idle, act;
      exp_t e;
      cyc = 0; reqc = 0; idle = 0; act = 0;
      forever begin
         @(posedge clk);
         #1;
         if (start_v != 2'b00) begin
            act = start_v[1] ? 1 : 0;
            cyc = 0; reqc = 0; idle = 0;
            acc_log.delete();
         end else begin
            cyc++;
            if (mem_req_v[act]) reqc++;
            if (busy_v[act] && !mem_req_v[act] && !done_v[act]) idle++;
         end
         for (int id = 0; id < 2; id++) begin
            if (done_v[id]) begin
               if (sb.size() == 0 || sb[0].id != id) begin
                  check($sformatf("dut%0d/unexpected_done", id), done_v[id], 1'b0);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "/value"},    value_v[id],     e.value);
                  check({e.name, "/ea"},       ea_v[id],        e.ea);
                  check({e.name, "/ea_valid"}, ea_valid_v[id],  e.ea_valid);
                  check({e.name, "/pc_next"},  pc_next_v[id],   e.pc_next);
                  check({e.name, "/sp_next"},  sp_next_v[id],   e.sp_next);
                  check({e.name, "/nw_used"},  nw_used_v[id],   e.nw_used);
                  check({e.name, "/illegal"},  illegal_v[id],   e.illegal);
                  check({e.name, "/latency"},  cyc,             e.lat);
                  check({e.name, "/idle"},     idle,            e.idle);
                  check({e.name, "/req_cyc"},  reqc,            e.reqc);
                  check({e.name, "/n_acc"},    acc_log.size(),  e.nacc);
                  if (e.nacc > 0 && acc_log.size() > 0) check({e.name, "/addr0"}, acc_log[0], e.a0);
                  if (e.nacc > 1 && acc_log.size() > 1) check({e.name, "/addr1"}, acc_log[1], e.a1);
               end
            end
         end
      end
   end

   task automatic issue(input exp_t e_in, input logic ib, input logic [5:0] f);
      exp_t e;
      e      = e_in;
      e.reqc = e.nacc * ack_dly;
      @(posedge clk);
      is_b_i = ib;
      field_i = f;
      start_v[e.id] = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      start_v = '0;
      for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
      check({e.name, "/timeout"}, sb.size(), 0);
      sb.delete();
      @(posedge clk);
      #1;
      check({e.name, "/hold"}, value_v[e.id], e.value);
   endtask

   initial begin
      RESET   = 1'b1;
      start_v = '0;
      is_b_i  = 1'b0;
      field_i = '0;
      sp_i    = 16'h8000;
      pc_i    = 16'h0100;
      ex_i    = 16'hE0E0;
      regs_i  = {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h0300, 16'h0010, 16'h0007};
      mem[16'h0100] = 16'hBEEF;
      mem[16'h0200] = 16'hFFF8;
      mem[16'h0008] = 16'h1234;
      mem[16'hFFFF] = 16'h5A5A;
      mem[16'h0010] = 16'h7777;
      mem[16'h0300] = 16'h0020;
      mem[16'h0400] = 16'h0010;
      repeat (3) @(posedge clk);
      #2 RESET = 1'b0;
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
         check($sformatf("dut%0d/reset_ctl", id),
               {mem_req_v[id], busy_v[id], done_v[id], ea_valid_v[id], nw_used_v[id], illegal_v[id]}, 6'b0);
         check($sformatf("dut%0d/reset_data", id),
               {value_v[id], ea_v[id], mem_addr_v[id], pc_next_v[id]}, 64'h0);
         check($sformatf("dut%0d/reset_sp", id), sp_next_v[id], 16'h0);
      end

      // Nextword literal
      pc_i = 16'h0100;
      issue(mk(0, "a1F_nw_lit", 16'hBEEF, 16'h0, 0, 16'h0101, 16'h8000, 1, 0, 1, 16'h0100, 0, 3, 0), 1'b0, 6'h1F);
      // [B+NW] with wrap: 0x0010 + 0xFFF8 = 0x0008
      pc_i = 16'h0200;
      issue(mk(0, "b11_reg_nw", 16'h1234, 16'h0008, 1, 16'h0201, 16'h8000, 1, 0, 2, 16'h0200, 16'h0008, 5, 0), 1'b1, 6'h11);
      // PUSH at SP=0 wraps to 0xFFFF
      pc_i = 16'h0100; sp_i = 16'h0000;
      issue(mk(0, "b18_push", 16'h5A5A, 16'hFFFF, 1, 16'h0100, 16'hFFFF, 0, 0, 1, 16'hFFFF, 0, 3, 0), 1'b1, 6'h18);
      // POP at SP=0xFFFF wraps to 0
      sp_i = 16'hFFFF;
      issue(mk(0, "a18_pop", 16'h5A5A, 16'hFFFF, 1, 16'h0100, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 3, 0), 1'b0, 6'h18);
      sp_i = 16'h8000;
      // Short literals and the illegal b literal
      issue(mk(0, "a20_lit", 16'hFFFF, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h20);
      issue(mk(0, "a3F_lit", 16'h001E, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h3F);
      issue(mk(0, "b20_illegal", 16'h0000, 16'h0, 0, 16'h0100, 16'h8000, 0, 1, 0, 0, 0, 1, 0), 1'b1, 6'h20);
      // Register and register-indirect operands
      issue(mk(0, "a02_reg_c", 16'h0300, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h02);
      issue(mk(0, "a09_ind_b", 16'h7777, 16'h0010, 1, 16'h0100, 16'h8000, 0, 0, 1, 16'h0010, 0, 3, 0), 1'b0, 6'h09);
      // [SP+NW] with wrap: 0xFFF0 + 0x0020 = 0x0010
      sp_i = 16'hFFF0; pc_i = 16'h0300;
      issue(mk(0, "a1A_pick", 16'h7777, 16'h0010, 1, 16'h0301, 16'hFFF0, 1, 0, 2, 16'h0300, 16'h0010, 5, 0), 1'b0, 6'h1A);
      sp_i = 16'h8000; pc_i = 16'h0100;
      issue(mk(0, "a1B_sp", 16'h8000, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h1B);
      issue(mk(0, "a1C_pc", 16'h0100, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h1C);
      issue(mk(0, "a1D_ex", 16'hE0E0, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h1D);

      // WAIT_TICKS=3, [NW]: 1 + (2+3) + (2+3) cycles, 6 idle ticks
      pc_i = 16'h0400;
      issue(mk(1, "w3_a1E_nw_ind", 16'h7777, 16'h0010, 1, 16'h0401, 16'h8000, 1, 0, 2, 16'h0400, 16'h0010, 11, 6), 1'b0, 6'h1E);
      pc_i = 16'h0100;

      // Asynchronous reset while an indirect read is pending
      ack_dly = 4;
      @(posedge clk);
      is_b_i = 1'b1; field_i = 6'h08; start_v[0] = 1'b1;
      @(posedge clk);
      start_v = '0;
      @(posedge clk);
      #1 check("rst_mid/req_before", mem_req_v[0], 1'b1);
      #1 RESET = 1'b1;
      #1;
      check("rst_mid/mem_req", mem_req_v[0], 1'b0);
      check("rst_mid/busy", busy_v[0], 1'b0);
      check("rst_mid/value", value_v[0], 16'h0);
      check("rst_mid/ea_addr", {ea_v[0], mem_addr_v[0], ea_valid_v[0]}, 33'h0);
      repeat (2) @(posedge clk);
      #2 RESET = 1'b0;
      ack_dly = 2;
      repeat (4) @(posedge clk);
      issue(mk(0, "after_rst_a00", 16'h0007, 16'h0, 0, 16'h0100, 16'h8000, 0, 0, 0, 0, 0, 1, 0), 1'b0, 6'h00);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
